button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Conditions one raw, asynchronous push-button or switch input for the lab's clocked logic.
- Synchronizes the input into the Clk domain with a multi-stage flip-flop chain, then rejects contact bounce with a counter-qualified FSM.
- Produces a clean level plus single-cycle rise/fall pulses.
- Sits directly upstream of the team's D flip-flop, register and counter stages, which consume Btn_Level as data or Btn_Rise as a one-shot enable.

Parameters:
- SYNC_STAGES, 2: synchronizer depth, legal range 2..4.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to commit a change (10 ms at 100 MHz), legal minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): counter width, derived; not overridden by users.

Ports:
- Clk  input  1  system clock, all logic on rising edge
- Rst_n  input  1  synchronous active-low reset, sampled on rising Clk
- Btn_In  input  1  raw asynchronous button, active-high, may bounce
- Btn_Level  output  1  debounced level, registered
- Btn_Rise  output  1  one-cycle pulse on committed 0->1
- Btn_Fall  output  1  one-cycle pulse on committed 1->0
- Busy  output  1  high while a candidate change is being qualified (WAIT_HI/WAIT_LO)

Behaviour:
- Reset (Rst_n=0 at a rising Clk):
  - All synchronizer stages go to 0.
  - State goes to STABLE_LO; counter goes to 0.
  - Btn_Level, Btn_Rise, Btn_Fall and Busy go to 0.
  - Reset overrides every other event in the same cycle.
- Synchronizer: Btn_Sync is the last of SYNC_STAGES registers; Btn_In reaches Btn_Sync SYNC_STAGES edges after it is captured.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if Btn_Sync=1, go to WAIT_HI and clear the counter; otherwise hold.
  - WAIT_HI:
    - If Btn_Sync=0, return to STABLE_LO and clear the counter. This is bounce rejection; no pulse is produced.
    - Else if counter==DEBOUNCE_CYCLES-1, go to STABLE_HI, set Btn_Level=1, and assert Btn_Rise for exactly one cycle.
    - Else increment the counter.
  - STABLE_HI and WAIT_LO: mirror images of STABLE_LO and WAIT_HI, with Btn_Fall as the pulse and Btn_Level cleared.
- Busy is 1 exactly while the state is WAIT_HI or WAIT_LO.
- Latency: when Btn_In stays stable from edge 0, the committing edge is edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Btn_Level and the pulse are visible after that edge.
- Counter:
  - Unsigned, CNT_W bits, never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
  - Cleared on every entry to a WAIT state and on every abort.
- Boundary conditions:
  - A bounce on the final qualifying sample (counter==DEBOUNCE_CYCLES-1 with Btn_Sync reverting) aborts. Btn_Level is unchanged and no pulse is produced.
  - Btn_Rise and Btn_Fall are never high in the same cycle.
  - Successive pulses are at least DEBOUNCE_CYCLES+1 cycles apart.
  - Reset asserted mid-WAIT aborts qualification with no pulse.
  - If Btn_In is held high through reset release, it is treated as a fresh press: Btn_Rise fires after the full latency.
  - Glitches shorter than DEBOUNCE_CYCLES samples never change Btn_Level.

Decomposition:
- Shared include debounce_defs.vh holds:
  - the 2-bit state encodings (STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3);
  - the default DEBOUNCE_CYCLES;
  - a simulation value of 8.
- One sub-module: sync_chain (parameter STAGES). It is a plain shift chain of rising-edge registers with the same synchronous active-low reset, and is reusable for other asynchronous lab inputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8):
- Reset check: hold Rst_n=0 for 3 cycles with Btn_In=1 -> all outputs 0 during reset. After release, Btn_Rise fires at edge 11 and Btn_Level=1 thereafter.
- Clean press: Btn_In 0->1 held high -> Busy high edges 3-10, Btn_Rise high for exactly one cycle after edge 11, Btn_Level=1.
- Bounce rejection: toggle Btn_In with periods of 3 cycles for 40 cycles, then hold 1 -> exactly one Btn_Rise, at 11 edges after the final stable transition.
- Late glitch: press, then drop Btn_In low for 1 cycle so that Btn_Sync is 0 when counter==7 -> return to STABLE_LO, Btn_Level stays 0, no pulse.
- Release: from STABLE_HI, drive Btn_In 1->0 held -> one Btn_Fall pulse at edge 11, Btn_Level=0, Btn_Rise never asserted.
- Mid-qualification reset: press, assert Rst_n=0 when counter==4 -> counter=0, state STABLE_LO, no pulse, Busy=0.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// debounce-length constants for hardware and for simulation.
package button_debouncer_pkg;

    // 2-bit state encoding; the values are fixed because other lab blocks decode them
    typedef enum logic [1:0] {
        StableLo = 2'd0,
        WaitHi   = 2'd1,
        StableHi = 2'd2,
        WaitLo   = 2'd3
    } state_t;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Short qualification window so simulations stay fast
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-stage synchronizer for one asynchronous input bit. Plain shift chain of
// rising-edge flops with synchronous active-low reset; the output is the last stage.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] stages_q;

    // Shift the raw input through the chain, stage 0 captures it first
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stages_q <= '0;
        end else begin
            stages_q <= {stages_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = stages_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes the raw input, then commits a level change
// only after DEBOUNCE_CYCLES consecutive stable samples. Emits a clean level and
// one-cycle rise/fall pulses; Busy flags an in-progress qualification.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Btn_In,
    output logic Btn_Level,
    output logic Btn_Rise,
    output logic Btn_Fall,
    output logic Busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .async_in (Btn_In),
        .sync_out (btn_sync)
    );

    // Debounce FSM with registered level, pulses and busy flag
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= StableLo;
            cnt_q     <= '0;
            Btn_Level <= 1'b0;
            Btn_Rise  <= 1'b0;
            Btn_Fall  <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below
            Btn_Rise <= 1'b0;
            Btn_Fall <= 1'b0;
            unique case (state_q)
                StableLo: begin
                    if (btn_sync) begin
                        state_q <= WaitHi;
                        cnt_q   <= '0;
                        Busy    <= 1'b1;
                    end
                end
                WaitHi: begin
                    if (!btn_sync) begin
                        // Bounce: abandon the candidate press silently
                        state_q <= StableLo;
                        cnt_q   <= '0;
                        Busy    <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StableHi;
                        Btn_Level <= 1'b1;
                        Btn_Rise  <= 1'b1;
                        Busy      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StableHi: begin
                    if (!btn_sync) begin
                        state_q <= WaitLo;
                        cnt_q   <= '0;
                        Busy    <= 1'b1;
                    end
                end
                WaitLo: begin
                    if (btn_sync) begin
                        // Bounce: abandon the candidate release silently
                        state_q <= StableHi;
                        cnt_q   <= '0;
                        Busy    <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StableLo;
                        Btn_Level <= 1'b0;
                        Btn_Fall  <= 1'b1;
                        Busy      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
